// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  localparam int INSTR_BYTES      = 4;
  localparam int DEFAULT_MEM_SIZE = 1024;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-issue instruction fetch with stall, redirect and optional fault checking
// Define FETCH_FAULT_EN to compile in misaligned-redirect and ROM bounds checking.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          MEM_SIZE = DEFAULT_MEM_SIZE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        br_taken,
  input  logic [63:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [31:0] fetch_count
);

  if (MEM_SIZE <= INSTR_BYTES || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_mem_size_check
    $error("instr_fetch: MEM_SIZE must be a power of two greater than 4");
  end

  fetch_state_t state, state_d;
  logic [63:0]  pc, pc_d;
  logic         out_valid_d;
  logic [31:0]  out_instr_d;
  logic [63:0]  out_pc_d;
  logic [31:0]  fetch_count_d;

  logic         capture_due;
  logic         count_inc;
  logic         fault_hit;
  logic [63:0]  pc_inc;
  logic [63:0]  redirect_pc;

  assign imem_addr   = pc;
  assign capture_due = !out_valid || out_ready;
  assign pc_inc      = pc + 64'(INSTR_BYTES);
  assign redirect_pc = br_target & ~64'(INSTR_BYTES - 1);
  // A word flushed by a redirect in the same cycle never reaches decode.
  assign count_inc   = (state == RUN) && out_valid && out_ready && !br_taken;

`ifdef FETCH_FAULT_EN
  logic [64:0] pc_last;
  assign pc_last   = {1'b0, pc} + 65'(INSTR_BYTES - 1);
  assign fault_hit = (br_taken && (br_target[1:0] != 2'b00)) ||
                     (!br_taken && capture_due && (pc_last >= 65'(MEM_SIZE)));
  assign fault     = (state == FAULT);
`else
  assign fault_hit = 1'b0;
  assign fault     = 1'b0;
`endif

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    out_valid_d   = out_valid;
    out_instr_d   = out_instr;
    out_pc_d      = out_pc;
    fetch_count_d = fetch_count + 32'(count_inc);
    case (state)
      IDLE: begin
        out_valid_d = 1'b0;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (fault_hit) begin
          state_d     = FAULT;
          out_valid_d = 1'b0;
        end else if (br_taken) begin
          pc_d        = redirect_pc;
          out_valid_d = 1'b0;
        end else if (capture_due) begin
          out_instr_d = imem_instr;
          out_pc_d    = pc;
          out_valid_d = 1'b1;
          pc_d        = pc_inc;
        end
      end
      FAULT: out_valid_d = 1'b0;
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= 32'h0;
      out_pc      <= 64'h0;
      fetch_count <= 32'h0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      out_valid   <= out_valid_d;
      out_instr   <= out_instr_d;
      out_pc      <= out_pc_d;
      fetch_count <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch (both FETCH_FAULT_EN builds)
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        br_taken = 1'b0;
  logic [63:0] br_target = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fault;
  logic [31:0] fetch_count;

  int total = 0;
  int bad = 0;

  logic [31:0] rom [0:255];

  instr_fetch dut (
    .clk(clk), .reset_n(reset_n), .start(start), .imem_addr(imem_addr),
    .imem_instr(imem_instr), .br_taken(br_taken), .br_target(br_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .fault(fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_at(input logic [63:0] a);
    if (a < 64'd1024) return rom[a[9:2]];
    return 32'hBAD0_0000 ^ a[31:0];
  endfunction

  always_comb imem_instr = rom_at(imem_addr);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; br_taken = 1'b0; br_target = 64'h0; out_ready = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  task automatic go();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Reset, start, stream with ready=1 until addr is presented, then stall on it.
  task automatic run_to(input logic [63:0] addr, output bit ok);
    ok = 1'b0;
    do_reset();
    out_ready = 1'b1;
    go();
    for (int i = 0; i < 30; i++) begin
      if (out_valid && out_pc == addr) begin ok = 1'b1; break; end
      cyc();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    br_taken = 1'b1; br_target = 64'h40; out_ready = 1'b1;
    repeat (3) cyc();
    br_taken = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL idle_redirect_ignored: got %h want 0", imem_addr); end
  endtask

  task automatic test_sequence();
    int n = 0;
    do_reset();
    out_ready = 1'b1;
    go();
    for (int i = 0; i < 20 && n < 4; i++) begin
      if (out_valid) begin
        total++; if (out_pc !== 64'(4 * n)) begin bad++; $display("FAIL seq_pc%0d: got %h want %h", n, out_pc, 4 * n); end
        total++; if (out_instr !== rom_at(64'(4 * n))) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", n, out_instr, rom_at(64'(4 * n))); end
        n++;
      end
      cyc();
    end
    out_ready = 1'b0;
    total++; if (n != 4) begin bad++; $display("FAIL seq_timeout: got %0d words want 4", n); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall();
    bit ok;
    run_to(64'h8, ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_reach8: got no word at 8 want one"); end
    repeat (3) begin
      cyc();
      total++; if (out_valid !== 1'b1 || out_pc !== 64'h8) begin bad++; $display("FAIL stall_hold_pc: got v=%b pc=%h want v=1 pc=8", out_valid, out_pc); end
      total++; if (out_instr !== rom_at(64'h8)) begin bad++; $display("FAIL stall_hold_instr: got %h want %h", out_instr, rom_at(64'h8)); end
      total++; if (imem_addr !== 64'hC) begin bad++; $display("FAIL stall_imem_addr: got %h want c", imem_addr); end
      total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL stall_count: got %0d want 2", fetch_count); end
    end
    out_ready = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'hC) begin bad++; $display("FAIL stall_resume: got v=%b pc=%h want v=1 pc=c", out_valid, out_pc); end
    total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stall_resume_count: got %0d want 3", fetch_count); end
  endtask

  task automatic test_redirect();
    bit ok;
    run_to(64'h8, ok);
    total++; if (!ok) begin bad++; $display("FAIL redir_reach8: got no word at 8 want one"); end
    br_taken = 1'b1; br_target = 64'h40;
    cyc();
    br_taken = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got %b want 0", out_valid); end
    out_ready = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h40) begin bad++; $display("FAIL redir_target: got v=%b pc=%h want v=1 pc=40", out_valid, out_pc); end
    total++; if (out_instr !== rom_at(64'h40)) begin bad++; $display("FAIL redir_instr: got %h want %h", out_instr, rom_at(64'h40)); end
    total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL redir_count: got %0d want 2", fetch_count); end
  endtask

  task automatic test_misaligned();
    do_reset();
    out_ready = 1'b1;
    go();
    cyc(); cyc();
    br_taken = 1'b1; br_target = 64'h42;
    cyc();
`ifdef FETCH_FAULT_EN
    total++; if (fault !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mis_fault: got f=%b v=%b want f=1 v=0", fault, out_valid); end
    br_target = 64'h0; start = 1'b1;
    repeat (3) cyc();
    br_taken = 1'b0; start = 1'b0;
    total++; if (fault !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL mis_sticky: got f=%b v=%b want f=1 v=0", fault, out_valid); end
    total++; if (imem_addr !== 64'h8) begin bad++; $display("FAIL mis_pc_held: got %h want 8", imem_addr); end
    total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL mis_count: got %0d want 1", fetch_count); end
    reset_n = 1'b0;
    #1;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL mis_reset_clears: got %b want 0", fault); end
    reset_n = 1'b1;
`else
    br_taken = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mis_flush: got %b want 0", out_valid); end
    cyc();
    total++; if (out_pc !== 64'h40 || fault !== 1'b0) begin bad++; $display("FAIL mis_masked: got pc=%h f=%b want pc=40 f=0", out_pc, fault); end
    total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL mis_count: got %0d want 1", fetch_count); end
`endif
  endtask

  task automatic test_bounds();
    do_reset();
    go();
    br_taken = 1'b1; br_target = 64'h3FC;
    cyc();
    br_taken = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bnd_flush: got %b want 0", out_valid); end
    out_ready = 1'b1;
    cyc();
    total++; if (out_valid !== 1'b1 || out_pc !== 64'h3FC) begin bad++; $display("FAIL bnd_last_word: got v=%b pc=%h want v=1 pc=3fc", out_valid, out_pc); end
    total++; if (out_instr !== rom_at(64'h3FC)) begin bad++; $display("FAIL bnd_last_instr: got %h want %h", out_instr, rom_at(64'h3FC)); end
    cyc();
`ifdef FETCH_FAULT_EN
    total++; if (fault !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bnd_fault: got f=%b v=%b want f=1 v=0", fault, out_valid); end
    total++; if (imem_addr !== 64'h400) begin bad++; $display("FAIL bnd_pc_held: got %h want 400", imem_addr); end
`else
    total++; if (out_pc !== 64'h400 || fault !== 1'b0) begin bad++; $display("FAIL bnd_nocheck: got pc=%h f=%b want pc=400 f=0", out_pc, fault); end
`endif
    total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL bnd_count: got %0d want 1", fetch_count); end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    go();
    repeat (4) cyc();
    out_ready = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b1 || fetch_count == 32'd0) begin bad++; $display("FAIL arst_pre: got v=%b cnt=%0d want v=1 cnt>0", out_valid, fetch_count); end
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid: got %b want 0", out_valid); end
    total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL arst_pc: got %h want 0", imem_addr); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL arst_count: got %0d want 0", fetch_count); end
    total++; if (out_pc !== 64'h0) begin bad++; $display("FAIL arst_out_pc: got %h want 0", out_pc); end
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_needs_start: got %b want 0", out_valid); end
    out_ready = 1'b0;
  endtask

  // Stream-level reference: accepted words must be consecutive addresses from the last redirect.
  task automatic test_random();
    logic [63:0] exp_addr = 64'h0;
    logic [63:0] tgt;
    int          exp_count = 0;
    bit          was_stalled = 1'b0;
    logic [63:0] held_pc = 64'h0;
    logic [31:0] held_instr = 32'h0;
    do_reset();
    go();
    for (int i = 0; i < 400; i++) begin
      total++; if (fetch_count !== 32'(exp_count)) begin bad++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, fetch_count, exp_count); end
      if (was_stalled) begin
        total++; if (out_valid !== 1'b1 || out_pc !== held_pc || out_instr !== held_instr) begin bad++; $display("FAIL rnd_stall@%0d: got v=%b pc=%h want pc=%h", i, out_valid, out_pc, held_pc); end
      end
      out_ready = 1'($urandom_range(0, 1));
      br_taken  = ($urandom_range(0, 9) == 0) || (exp_addr > 64'h380);
      tgt = 64'($urandom_range(0, 127)) * 64'd4;
`ifndef FETCH_FAULT_EN
      tgt = tgt | 64'($urandom_range(0, 3));
`endif
      br_target = tgt;
      if (out_valid && out_ready && !br_taken) begin
        total++; if (out_pc !== exp_addr || out_instr !== rom_at(exp_addr)) begin bad++; $display("FAIL rnd_word@%0d: got pc=%h i=%h want pc=%h i=%h", i, out_pc, out_instr, exp_addr, rom_at(exp_addr)); end
        exp_addr = exp_addr + 64'd4;
        exp_count++;
      end
      was_stalled = out_valid && !out_ready && !br_taken;
      held_pc = out_pc;
      held_instr = out_instr;
      if (br_taken) exp_addr = {tgt[63:2], 2'b00};
      cyc();
    end
    br_taken = 1'b0; out_ready = 1'b0;
    total++; if (fetch_count !== 32'(exp_count) || fault !== 1'b0) begin bad++; $display("FAIL rnd_final: got cnt=%0d f=%b want cnt=%0d f=0", fetch_count, fault, exp_count); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_misaligned();
    test_bounds();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, the PC loaded on reset.
REQ-002 SHALL have parameter MEM_SIZE, default 1024, the instruction memory size in bytes; must be a power of two greater than 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begins fetching from IDLE.
REQ-006 SHALL have port imem_addr, output, 64 bits: byte address driven to the instruction ROM.
REQ-007 SHALL have port imem_instr, input, 32 bits: combinational ROM read data for imem_addr.
REQ-008 SHALL have port br_taken, input, 1 bit: redirect request.
REQ-009 SHALL have port br_target, input, 64 bits: redirect byte address.
REQ-010 SHALL have port out_valid, output, 1 bit: out_instr/out_pc hold a valid fetched word.
REQ-011 SHALL have port out_ready, input, 1 bit: the decode stage accepts the word this cycle.
REQ-012 SHALL have port out_instr, output, 32 bits: fetched instruction.
REQ-013 SHALL have port out_pc, output, 64 bits: address of out_instr.
REQ-014 SHALL have port fault, output, 1 bit: sticky fetch fault.
REQ-015 SHALL have port fetch_count, output, 32 bits: number of words accepted by decode.

Function
REQ-016 SHALL implement states IDLE, RUN and FAULT.
- IDLE->RUN when start=1.
- RUN->FAULT on a fault condition.
- FAULT is left only by reset.
REQ-017 SHALL drive imem_addr combinationally from the pc register in every state.
REQ-018 SHALL capture in RUN when out_valid=0 or out_ready=1: out_instr<=imem_instr, out_pc<=pc, out_valid<=1, pc<=pc+4; latency is one cycle from pc to out_valid.
REQ-019 SHALL hold pc, out_instr, out_pc and out_valid unchanged while out_valid=1 and out_ready=0 (stall).
REQ-020 SHALL, on br_taken=1 in RUN, load pc<=br_target and out_valid<=0 (flush) regardless of stall; no capture occurs that cycle.
REQ-021 SHALL apply priority reset > fault > br_taken > stall > advance.
REQ-022 SHALL ignore br_taken and start in FAULT.
- In FAULT: out_valid=0 and pc held.
REQ-023 SHALL ignore br_taken in IDLE.
- In IDLE: out_valid=0.
REQ-024 SHALL compute pc+4 modulo 2^64 with no carry out.
REQ-025 SHALL increment fetch_count on each cycle with out_valid=1 and out_ready=1, wrapping from 32'hFFFFFFFF to 0.
- A word flushed by br_taken is not counted.

Reset
REQ-026 SHALL, while reset_n=0, force state=IDLE, pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fault=0, fetch_count=0, asynchronously.
REQ-027 SHALL discard any in-flight word when reset is asserted mid-operation; a fresh start is required after release.

Configuration
REQ-028 SHALL use macro FETCH_FAULT_EN to compile fault checking in or out.
REQ-029 SHALL, with FETCH_FAULT_EN defined, enter FAULT and set fault=1 in either case:
- br_taken=1 with br_target[1:0]!=0;
- a capture is due with pc+3 >= MEM_SIZE.
In both cases out_valid<=0 and pc is not updated.
REQ-030 SHALL, with FETCH_FAULT_EN undefined, tie fault to 0, never enter FAULT, load pc<={br_target[63:2],2'b00} on redirect, and perform no bounds check.

Structure
REQ-031 SHALL place the state enum (IDLE/RUN/FAULT), the INSTR_BYTES=4 constant and the default MEM_SIZE in package fetch_pkg.
REQ-032 SHALL be a single module with no sub-module; the PC adder and counter are inline.

Verification
REQ-033 SHALL cover reset then start, with out_ready=1 held and a ROM loaded with words W0..W3.
- Required: out_pc sequence 0,4,8,12; out_instr W0..W3; fetch_count=4 after 4 accepts.
REQ-034 SHALL cover a stall: out_ready=0 for 3 cycles at out_pc=8.
- Required: out_pc=8, out_instr and imem_addr=12 stable; fetch_count unchanged; resumes at 12.
REQ-035 SHALL cover a redirect: br_taken=1, br_target=0x40 while stalled at out_pc=8.
- Required: next cycle out_valid=0; following cycle out_pc=0x40; the word at 8 is not counted.
REQ-036 SHALL cover a misaligned redirect with FETCH_FAULT_EN: br_target=0x42.
- Required: fault=1 and out_valid=0 next cycle; later br_taken to 0x0 is ignored; fault clears only on reset_n=0.
REQ-037 SHALL cover the bounds check with FETCH_FAULT_EN, MEM_SIZE=1024: redirect to 0x3FC, then advance.
- Required: word at 0x3FC delivered; capture at 0x400 raises fault.
- Without the macro: out_pc=0x400, fault=0.
REQ-038 SHALL cover asynchronous reset asserted mid-cycle during RUN with out_valid=1.
- Required: out_valid=0, pc=RESET_PC and fetch_count=0 immediately, without waiting for a clk edge.
